// File: rtl/sb_drain.sv
// Store-buffer drain engine: pops one committed store at a time, issues it as a
// single-beat memory write and waits for its response before taking the next.
module sb_drain #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32,
   parameter int unsigned STRB_W = DATA_W / 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush_i,
   // store-buffer entry handshake (receiver side)
   input  logic              sb_valid_i,
   input  logic [ADDR_W-1:0] sb_addr_i,
   input  logic [DATA_W-1:0] sb_data_i,
   input  logic [STRB_W-1:0] sb_strb_i,
   output logic              sb_ready_o,
   // data-memory write port
   output logic              wreq_valid_o,
   input  logic              wreq_ready_i,
   output logic [ADDR_W-1:0] wreq_addr_o,
   output logic [DATA_W-1:0] wreq_data_o,
   output logic [STRB_W-1:0] wreq_strb_o,
   input  logic              wresp_valid_i,
   input  logic              wresp_err_i,
   // status
   output logic              busy_o,
   output logic              err_o,
   output logic [31:0]       drained_cnt_o
);

   typedef enum logic [1:0] {StIdle, StReq, StResp} state_e;

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic [STRB_W-1:0] strb_q, strb_d;
   logic              err_q, err_d;
   logic [31:0]       cnt_q, cnt_d;
   logic              accept;

   // Ready never looks at valid, so upstream can't form a combinational loop through us.
   assign sb_ready_o = (state_q == StIdle) && !flush_i;
   assign accept     = sb_valid_i && sb_ready_o;

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      data_d  = data_q;
      strb_d  = strb_q;
      err_d   = err_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         StIdle: begin
            if (accept) begin
               addr_d = sb_addr_i;
               data_d = sb_data_i;
               strb_d = sb_strb_i;
               // A zero-strobe store writes nothing; retire it without a bus request.
               if (sb_strb_i != '0) begin
                  state_d = StReq;
               end else begin
                  cnt_d = cnt_q + 32'd1;
               end
            end
         end
         StReq: begin
            if (wreq_ready_i) begin
               state_d = StResp;
            end
         end
         StResp: begin
            if (wresp_valid_i) begin
               state_d = StIdle;
               cnt_d   = cnt_q + 32'd1;
               if (wresp_err_i) begin
                  err_d = 1'b1;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         addr_q  <= '0;
         data_q  <= '0;
         strb_q  <= '0;
         err_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         strb_q  <= strb_d;
         err_q   <= err_d;
         cnt_q   <= cnt_d;
      end
   end

   assign wreq_valid_o  = (state_q == StReq);
   assign wreq_addr_o   = addr_q;
   assign wreq_data_o   = data_q;
   assign wreq_strb_o   = strb_q;
   assign busy_o        = (state_q != StIdle);
   assign err_o         = err_q;
   assign drained_cnt_o = cnt_q;

endmodule
